// File: rtl/tc0480scp_rom_cache_if.sv
// Bus bundle between the TC0480SCP tile fetch port, the ROM cache and the SDRAM controller.
// The slave modport is the cache; the master modport is its environment
// (the tile fetcher on the rom_* side and the SDRAM controller on the sdr_* side).
interface tc0480scp_rom_cache_if #(
    parameter int SDR_AW = 27
);
    logic [22:0]       rom_address;
    logic              rom_req;
    logic              rom_ack;
    logic [63:0]       rom_data;
    logic [SDR_AW-1:0] sdr_addr;
    logic              sdr_req;
    logic              sdr_ack;
    logic [63:0]       sdr_data;
    logic              flush;
    logic              busy;

    modport master (
        output rom_address, rom_req,
        input  rom_ack, rom_data,
        input  sdr_addr, sdr_req,
        output sdr_ack, sdr_data,
        output flush,
        input  busy
    );

    modport slave (
        input  rom_address, rom_req,
        output rom_ack, rom_data,
        output sdr_addr, sdr_req,
        input  sdr_ack, sdr_data,
        input  flush,
        output busy
    );
endinterface

// File: rtl/tc0480scp_rom_cache.sv
// Direct-mapped read-only line cache for TC0480SCP BG tile rows.
// One 64-bit tile row per line; misses are filled from SDRAM over a toggle handshake.
// Valid bits live in flops so a flush can walk them clear one line per cycle.
module tc0480scp_rom_cache #(
    parameter int                LINES_LOG2 = 6,
    parameter int                SDR_AW     = 27,
    parameter logic [SDR_AW-1:0] SDR_BASE   = '0
) (
    input logic                   clk,
    input logic                   reset,
    tc0480scp_rom_cache_if.slave  bus
);

    localparam int LINES = 1 << LINES_LOG2;
    localparam int TAG_W = 23 - 3 - LINES_LOG2;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL
    } state_t;

    state_t                  state_q, state_d;
    logic [LINES_LOG2-1:0]   init_idx_q, init_idx_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic                    flush_pending_q, flush_pending_d;
    logic [22:3]             addr_q, addr_d;
    logic                    rom_ack_q, rom_ack_d;
    logic [63:0]             rom_data_q, rom_data_d;
    logic [SDR_AW-1:0]       sdr_addr_q, sdr_addr_d;
    logic                    sdr_req_q, sdr_req_d;
    logic                    busy_q, busy_d;

    logic [63:0]             data_ram [LINES];
    logic [TAG_W-1:0]        tag_ram  [LINES];
    logic [63:0]             rd_data_q;
    logic [TAG_W-1:0]        rd_tag_q;
    logic                    ram_we;
    logic                    ram_re;

    logic [LINES_LOG2-1:0]   req_idx;
    logic [LINES_LOG2-1:0]   line_idx;
    logic [TAG_W-1:0]        line_tag;
    logic                    hit;
    logic                    flush_seen;

    assign req_idx    = bus.rom_address[3 +: LINES_LOG2];
    assign line_idx   = addr_q[3 +: LINES_LOG2];
    assign line_tag   = addr_q[22 -: TAG_W];
    assign hit        = valid_q[line_idx] && (rd_tag_q == line_tag);
    assign flush_seen = flush_pending_q | bus.flush;

    assign bus.rom_ack  = rom_ack_q;
    assign bus.rom_data = rom_data_q;
    assign bus.sdr_addr = sdr_addr_q;
    assign bus.sdr_req  = sdr_req_q;
    assign bus.busy     = busy_q;

    // Next-state and registered-output logic for the lookup / fill / invalidate sequencer.
    always_comb begin
        state_d         = state_q;
        init_idx_d      = init_idx_q;
        valid_d         = valid_q;
        flush_pending_d = flush_seen;
        addr_d          = addr_q;
        rom_ack_d       = rom_ack_q;
        rom_data_d      = rom_data_q;
        sdr_addr_d      = sdr_addr_q;
        sdr_req_d       = sdr_req_q;
        busy_d          = busy_q;
        ram_we          = 1'b0;
        ram_re          = 1'b0;

        case (state_q)
            ST_INIT: begin
                busy_d             = 1'b1;
                flush_pending_d    = 1'b0;
                valid_d[init_idx_q] = 1'b0;
                // No read can be outstanding here, so keep the SDRAM handshake aligned.
                sdr_req_d          = bus.sdr_ack;
                if (bus.flush) begin
                    init_idx_d = '0;
                end else if (init_idx_q == LINES_LOG2'(LINES - 1)) begin
                    init_idx_d = '0;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    init_idx_d = init_idx_q + LINES_LOG2'(1);
                end
            end

            ST_IDLE: begin
                if (flush_seen) begin
                    flush_pending_d = 1'b0;
                    init_idx_d      = '0;
                    busy_d          = 1'b1;
                    state_d         = ST_INIT;
                end else if (bus.rom_req != rom_ack_q) begin
                    addr_d  = bus.rom_address[22:3];
                    ram_re  = 1'b1;
                    state_d = ST_LOOKUP;
                end
            end

            ST_LOOKUP: begin
                if (hit) begin
                    rom_data_d = rd_data_q;
                    rom_ack_d  = bus.rom_req;
                    state_d    = ST_IDLE;
                end else begin
                    sdr_addr_d = SDR_BASE + SDR_AW'({addr_q, 3'b000});
                    sdr_req_d  = ~sdr_req_q;
                    state_d    = ST_FILL;
                end
            end

            ST_FILL: begin
                if (bus.sdr_ack == sdr_req_q) begin
                    rom_data_d = bus.sdr_data;
                    rom_ack_d  = bus.rom_req;
                    if (!flush_seen) begin
                        ram_we            = 1'b1;
                        valid_d[line_idx] = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State and output registers; reset realigns both toggle handshakes so nothing stale completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_INIT;
            init_idx_q      <= '0;
            valid_q         <= '0;
            flush_pending_q <= 1'b0;
            addr_q          <= '0;
            rom_ack_q       <= bus.rom_req;
            rom_data_q      <= '0;
            sdr_addr_q      <= '0;
            sdr_req_q       <= bus.sdr_ack;
            busy_q          <= 1'b1;
        end else begin
            state_q         <= state_d;
            init_idx_q      <= init_idx_d;
            valid_q         <= valid_d;
            flush_pending_q <= flush_pending_d;
            addr_q          <= addr_d;
            rom_ack_q       <= rom_ack_d;
            rom_data_q      <= rom_data_d;
            sdr_addr_q      <= sdr_addr_d;
            sdr_req_q       <= sdr_req_d;
            busy_q          <= busy_d;
        end
    end

    // Line data and tag storage with a one-cycle registered read issued from IDLE.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            data_ram[line_idx] <= bus.sdr_data;
            tag_ram[line_idx]  <= line_tag;
        end
        if (ram_re) begin
            rd_data_q <= data_ram[req_idx];
            rd_tag_q  <= tag_ram[req_idx];
        end
    end

endmodule

// File: tb/tb_tc0480scp_rom_cache.sv
// Scoreboard bench for tc0480scp_rom_cache: directed requests push their expected row,
// a monitor pops and compares on every rom_ack toggle, and a small SDRAM model answers fills.
module tb_tc0480scp_rom_cache;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    tc0480scp_rom_cache_if #(.SDR_AW(27)) bus_if ();

    tc0480scp_rom_cache #(
        .LINES_LOG2 (6),
        .SDR_AW     (27),
        .SDR_BASE   (27'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int          checks = 0;
    int          failures = 0;
    logic [63:0] sb [$];
    int          sdr_count = 0;
    logic [26:0] last_sdr_addr = '0;
    int          sdr_delay = 5;
    int          ack_count = 0;
    logic        prev_ack = 1'b0;

    // SDRAM contents: one hand-picked row, everything else derived from the byte address.
    function automatic logic [63:0] sdrModel(input logic [26:0] a);
        if (a == 27'h0012340) return 64'hDEADBEEF_01234567;
        return {32'hC0DE0000 + 32'(a), 32'h0BADF00D ^ 32'(a)};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [22:0] addr, input logic [63:0] exp_data);
        bus_if.rom_address = addr;
        bus_if.rom_req     = ~bus_if.rom_req;
        sb.push_back(exp_data);
    endtask

    task automatic waitAck(input int budget, output int lat);
        lat = 0;
        while (bus_if.rom_ack != bus_if.rom_req && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        if (bus_if.rom_ack != bus_if.rom_req) begin
            checks++;
            failures++;
            $display("[TB] FAIL ack_timeout: got no ack after %0d cycles, required ack", lat);
        end
    endtask

    task automatic waitSdr(input int start, input int budget);
        int n;
        n = 0;
        while (sdr_count == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sdr_count == start) begin
            checks++;
            failures++;
            $display("[TB] FAIL sdr_timeout: got no sdr_req after %0d cycles, required one", n);
        end
    endtask

    task automatic countBusy(output int n);
        int w;
        w = 0;
        while (!bus_if.busy && w < 20) begin
            @(negedge clk);
            w++;
        end
        n = 0;
        while (bus_if.busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    // SDRAM controller model: answers each pending read after sdr_delay cycles by toggling sdr_ack.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus_if.sdr_req != bus_if.sdr_ack) begin
                sdr_count++;
                last_sdr_addr = bus_if.sdr_addr;
                repeat (sdr_delay) @(negedge clk);
                bus_if.sdr_data = sdrModel(last_sdr_addr);
                bus_if.sdr_ack  = ~bus_if.sdr_ack;
            end
        end
    end

    // Monitor: every rom_ack toggle outside reset must match the oldest expected row.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ack = bus_if.rom_ack;
            end else if (bus_if.rom_ack != prev_ack) begin
                prev_ack = bus_if.rom_ack;
                ack_count++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_ack: got ack with data %0h, required no ack", bus_if.rom_data);
                end else begin
                    checkOutput("rom_data", bus_if.rom_data, sb.pop_front());
                    checkOutput("ack_eq_req", 64'(bus_if.rom_ack), 64'(bus_if.rom_req));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, required completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    logic [22:0] conf_addr [3];
    logic [63:0] conf_data [3];

    initial begin
        int n;
        int lat;
        int sc;
        int a0;

        conf_addr[0] = 23'h000008; conf_data[0] = 64'hC0DE0008_0BADF005;
        conf_addr[1] = 23'h000208; conf_data[1] = 64'hC0DE0208_0BADF205;
        conf_addr[2] = 23'h000008; conf_data[2] = 64'hC0DE0008_0BADF005;

        reset              = 1'b1;
        bus_if.rom_address = '0;
        bus_if.rom_req     = 1'b1;
        bus_if.sdr_ack     = 1'b1;
        bus_if.sdr_data    = '0;
        bus_if.flush       = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("reset_busy", 64'(bus_if.busy), 64'd1);
        checkOutput("reset_rom_data", bus_if.rom_data, 64'd0);
        checkOutput("reset_sdr_addr", 64'(bus_if.sdr_addr), 64'd0);
        checkOutput("reset_rom_ack", 64'(bus_if.rom_ack), 64'd1);
        checkOutput("reset_sdr_req", 64'(bus_if.sdr_req), 64'd1);

        $display("[TB] init sweep with a request arriving mid-init");
        reset = 1'b0;
        a0 = ack_count;
        n = 0;
        while (bus_if.busy && n < 200) begin
            if (n == 10) applyStimulus(23'h000100, 64'hC0DE0100_0BADF10D);
            n++;
            @(negedge clk);
        end
        checkOutput("init_busy_cycles", 64'(n), 64'd64);
        checkOutput("init_no_early_ack", 64'(ack_count - a0), 64'd0);
        checkOutput("init_req_pending", 64'(bus_if.rom_ack == bus_if.rom_req), 64'd0);
        waitAck(40, lat);
        checkOutput("init_req_fill_count", 64'(sdr_count), 64'd1);

        $display("[TB] cold miss");
        sc = sdr_count;
        @(negedge clk);
        applyStimulus(23'h012340, 64'hDEADBEEF_01234567);
        waitAck(40, lat);
        checkOutput("miss_sdr_addr", 64'(last_sdr_addr), 64'h0012340);
        checkOutput("miss_sdr_count", 64'(sdr_count - sc), 64'd1);

        $display("[TB] repeat hits");
        sc = sdr_count;
        @(negedge clk);
        applyStimulus(23'h012340, 64'hDEADBEEF_01234567);
        waitAck(40, lat);
        checkOutput("hit_latency", 64'(lat), 64'd2);
        @(negedge clk);
        applyStimulus(23'h012347, 64'hDEADBEEF_01234567);
        waitAck(40, lat);
        checkOutput("hit_low_bits_latency", 64'(lat), 64'd2);
        checkOutput("hit_sdr_count", 64'(sdr_count - sc), 64'd0);

        $display("[TB] conflict misses");
        for (int i = 0; i < 3; i++) begin
            sc = sdr_count;
            @(negedge clk);
            applyStimulus(conf_addr[i], conf_data[i]);
            waitAck(40, lat);
            checkOutput("conflict_sdr_count", 64'(sdr_count - sc), 64'd1);
        end

        $display("[TB] flush during fill");
        sc = sdr_count;
        @(negedge clk);
        applyStimulus(23'h000010, 64'hC0DE0010_0BADF01D);
        waitSdr(sc, 20);
        @(negedge clk);
        bus_if.flush = 1'b1;
        @(negedge clk);
        bus_if.flush = 1'b0;
        waitAck(40, lat);
        countBusy(n);
        checkOutput("flush_busy_cycles", 64'(n), 64'd64);
        sc = sdr_count;
        @(negedge clk);
        applyStimulus(23'h000010, 64'hC0DE0010_0BADF01D);
        waitAck(40, lat);
        checkOutput("flush_refill_count", 64'(sdr_count - sc), 64'd1);

        $display("[TB] reset during fill");
        sdr_delay = 2;
        sc = sdr_count;
        @(negedge clk);
        applyStimulus(23'h000018, 64'hC0DE0018_0BADF015);
        waitSdr(sc, 20);
        reset = 1'b1;
        sb.delete();
        repeat (5) @(negedge clk);
        checkOutput("rst_sdr_sync", 64'(bus_if.sdr_req), 64'(bus_if.sdr_ack));
        checkOutput("rst_rom_sync", 64'(bus_if.rom_ack), 64'(bus_if.rom_req));
        reset = 1'b0;
        a0 = ack_count;
        repeat (70) @(negedge clk);
        checkOutput("rst_no_spurious_ack", 64'(ack_count - a0), 64'd0);
        checkOutput("rst_busy_done", 64'(bus_if.busy), 64'd0);
        checkOutput("rst_sdr_still_sync", 64'(bus_if.sdr_req), 64'(bus_if.sdr_ack));
        sdr_delay = 5;
        sc = sdr_count;
        @(negedge clk);
        applyStimulus(23'h012340, 64'hDEADBEEF_01234567);
        waitAck(40, lat);
        checkOutput("rst_next_miss_count", 64'(sdr_count - sc), 64'd1);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
